// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: single-cycle loads/stores in SERVE,
// plus a host bulk-load port, a streaming dump port and a power-on clear sweep.
module data_mem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic              busy,
    output logic              err_access,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {CLEAR, SERVE, LOAD, DUMP} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                cpu_wr, cpu_rd, last_ptr, done_nxt;

    assign last_ptr = (ptr == ADDR_W'(DEPTH - 1));
    assign cpu_wr   = (state == SERVE) && !CEN && !WEN;
    assign cpu_rd   = (state == SERVE) && !CEN && !OEN;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_addr  = ptr;
        mem_wdata = '0;
        done_nxt  = 1'b0;
        case (state)
            CLEAR: begin
                mem_we  = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (last_ptr) state_nxt = SERVE;
            end
            SERVE: begin
                if (cpu_wr) begin
                    mem_we    = 1'b1;
                    mem_addr  = A;
                    mem_wdata = Data2Mem;
                end
                // A pending CPU access keeps the bulk load waiting; dump always wins.
                if (dump_req) begin
                    state_nxt = DUMP;
                    ptr_nxt   = '0;
                end else if (load_valid && CEN) begin
                    state_nxt = LOAD;
                    ptr_nxt   = '0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = load_data;
                    ptr_nxt   = ptr + 1'b1;
                    if (load_last) state_nxt = SERVE;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    ptr_nxt = ptr + 1'b1;
                    if (last_ptr) begin
                        state_nxt = SERVE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            ptr        <= '0;
            dump_done  <= 1'b0;
            err_access <= 1'b0;
            wr_count   <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            dump_done <= done_nxt;
            if (busy && !CEN) err_access <= 1'b1;
            if (cpu_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end

    // No write lands on a reset edge; the following CLEAR sweep re-zeroes anyway.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem[mem_addr] <= mem_wdata;
    end

    assign busy        = (state != SERVE);
    assign load_ready  = (state == LOAD);
    assign dump_valid  = (state == DUMP);
    assign dump_addr   = dump_valid ? ptr : '0;
    assign dump_data   = dump_valid ? mem[ptr] : '0;
    assign ReadDataMem = cpu_rd ? mem[A] : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table for CPU accesses, hand sequences for
// load/dump/reset corners, and randomized CPU traffic against an array model.
module tb_data_mem_responder;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int DEP = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem, ReadDataMem;
    logic          load_valid, load_last, load_ready;
    logic [DW-1:0] load_data;
    logic          dump_req, dump_valid, dump_ready, dump_done;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          busy, err_access;
    logic [15:0]   wr_count;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
        .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .dump_req(dump_req), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done), .busy(busy), .err_access(err_access), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] mm [DEP];
    int exp_wr;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        CEN = !(w || r);
        WEN = !w;
        OEN = !r;
        A = a;
        Data2Mem = d;
    endtask

    task automatic idle_inputs;
        cpu(1'b0, 1'b0, '0, '0);
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        dump_req = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic read_check(input int a);
        cpu(1'b0, 1'b1, AW'(a), '0);
        #1;
        check($sformatf("read mem[%0d]", a), ReadDataMem, mm[a]);
        tick;
        cpu(1'b0, 1'b0, '0, '0);
    endtask

    // Counts busy cycles until SERVE; optionally attempts a CPU write to A=9 mid-clear.
    task automatic wait_clear(input logic poke);
        int n = 0;
        while (busy && n < 300) begin
            if (poke && n == 60) cpu(1'b1, 1'b1, AW'(9), 32'h99999999);
            else cpu(1'b0, 1'b0, '0, '0);
            #1;
            if (poke && n == 60) check("busy read gives 0", ReadDataMem, 0);
            n++;
            tick;
        end
        cpu(1'b0, 1'b0, '0, '0);
        check("clear busy cycles", n, 128);
    endtask

    task automatic dump_start;
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
    endtask

    task automatic dump_drain(input int gap_pct, input int stop_at);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_at && cyc < 3000) begin
            dump_ready = ($urandom_range(0, 99) >= gap_pct);
            #1;
            if (dump_ready) begin
                check("dump_valid", dump_valid, 1);
                check($sformatf("dump_addr #%0d", idx), dump_addr, 64'(idx));
                check($sformatf("dump_data #%0d", idx), dump_data, mm[idx]);
                idx++;
            end
            tick;
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump word count", idx, stop_at);
    endtask

    task automatic dump_finish(input int gap_pct);
        int dc;
        dump_drain(gap_pct, DEP);
        #1;
        dc = dump_done;
        check("dump_done after last", dump_done, 1);
        check("dump_valid after last", dump_valid, 0);
        check("serve after dump", busy, 0);
        repeat (3) begin
            tick;
            dc += dump_done;
        end
        check("dump_done pulses", dc, 1);
    endtask

    task automatic load_words(input int n, input int gap_max, input logic rnd);
        logic [DW-1:0] d;
        load_valid = 1'b1; load_data = 32'hBAD0BAD0; load_last = 1'b1;
        #1;
        check("load entry ready low", load_ready, 0);
        tick;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                load_valid = 1'b0;
                #1;
                check("load ready in gap", load_ready, 1);
                tick;
            end
            d = rnd ? DW'($urandom) : DW'(i + 1);
            load_valid = 1'b1; load_data = d; load_last = (i == n - 1);
            #1;
            check($sformatf("load_ready word %0d", i), load_ready, 1);
            mm[i % DEP] = d;
            tick;
        end
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        check("back to serve after load", busy, 0);
        check("load_ready low after load", load_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 7'd5,   32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 7'd5,   32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 7'd5,   32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 7'd5,   32'h0,        32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 7'd5,   32'h0,        32'h0};
        tbl[5] = '{1'b0, 1'b1, 7'd6,   32'h0,        32'h0};
        tbl[6] = '{1'b1, 1'b0, 7'd127, 32'hFFFFFFFF, 32'h0};
        tbl[7] = '{1'b0, 1'b1, 7'd127, 32'h0,        32'hFFFFFFFF};
        tbl[8] = '{1'b0, 1'b0, 7'd127, 32'h0,        32'h0};
        tbl[9] = '{1'b0, 1'b1, 7'd0,   32'h0,        32'h0};
        for (int i = 0; i < DEP; i++) mm[i] = '0;
        exp_wr = 0;

        idle_inputs;
        rst_n = 1'b0;
        repeat (3) tick;
        check("rst busy", busy, 1);
        check("rst dump_valid", dump_valid, 0);
        check("rst load_ready", load_ready, 0);
        check("rst ReadDataMem", ReadDataMem, 0);
        check("rst err_access", err_access, 0);
        check("rst wr_count", wr_count, 0);
        check("rst dump_done", dump_done, 0);
        check("rst dump_addr", dump_addr, 0);
        rst_n = 1'b1;
        wait_clear(1'b0);
        check("err_access after clean clear", err_access, 0);

        dump_start;
        dump_finish(0);

        for (int i = 0; i < 10; i++) begin
            cpu(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            #1;
            check($sformatf("tbl[%0d] ReadDataMem", i), ReadDataMem, tbl[i].exp_rd);
            if (tbl[i].wr) begin
                mm[tbl[i].a] = tbl[i].d;
                exp_wr++;
            end
            tick;
        end
        cpu(1'b0, 1'b0, '0, '0);
        #1;
        check("wr_count after table", wr_count, 64'(exp_wr));

        load_words(3, 2, 1'b0);
        for (int a = 0; a < 4; a++) read_check(a);
        load_words(130, 1, 1'b1);
        read_check(0);
        read_check(1);
        read_check(2);
        read_check(127);

        cpu(1'b0, 1'b1, 7'd1, '0);
        load_valid = 1'b1;
        #1;
        check("cpu beats load rd", ReadDataMem, mm[1]);
        tick;
        load_valid = 1'b0;
        cpu(1'b0, 1'b0, '0, '0);
        #1;
        check("cpu beats load: no LOAD", load_ready, 0);
        check("cpu beats load: serve", busy, 0);

        for (int i = 0; i < 300; i++) begin
            int op;
            logic w, r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            op = $urandom_range(0, 3);
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
            d = DW'($urandom);
            w = (op == 1 || op == 3);
            r = (op == 2 || op == 3);
            cpu(w, r, a, d);
            #1;
            check($sformatf("rand rd #%0d", i), ReadDataMem, r ? mm[a] : '0);
            if (w) begin
                mm[a] = d;
                exp_wr++;
            end
            tick;
        end
        cpu(1'b0, 1'b0, '0, '0);
        #1;
        check("wr_count after random", wr_count, 64'(exp_wr));

        dump_req = 1'b1; load_valid = 1'b1;
        tick;
        dump_req = 1'b0; load_valid = 1'b0;
        #1;
        check("dump wins: dump_valid", dump_valid, 1);
        check("dump wins: load_ready", load_ready, 0);
        repeat (4) begin
            tick;
            check("stall dump_addr", dump_addr, 0);
            check("stall dump_data", dump_data, mm[0]);
        end
        dump_finish(30);

        dump_start;
        dump_drain(0, 40);
        #1;
        check("mid-dump addr", dump_addr, 40);
        check("mid-dump data", dump_data, mm[40]);
        rst_n = 1'b0;
        tick;
        #1;
        check("reset mid-dump dump_valid", dump_valid, 0);
        check("reset mid-dump busy", busy, 1);
        rst_n = 1'b1;
        for (int i = 0; i < DEP; i++) mm[i] = '0;
        wait_clear(1'b1);
        #1;
        check("err_access sticky", err_access, 1);
        check("wr_count after reset", wr_count, 0);
        read_check(9);
        read_check(5);
        dump_start;
        dump_finish(25);
        check("err_access still set", err_access, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
